par_tx: RTL and testbench

Serial parity-frame transmitter. It is the sending end of the single-bit serial line checked by the team's parity receiver FSM. It latches a parallel word on a start request and shifts it out one bit per clock: start bit, data LSB-first, parity bit, stop bit. Moore-style: the serial output depends only on registered state and datapath.

---
 rtl/par_pkg.sv | 13 +
 rtl/par_tx_if.sv | 10 +
 rtl/par_tx_shift.sv | 33 +++
 rtl/par_tx.sv | 43 ++++
 tb/tb_par_tx.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/par_pkg.sv
// par_pkg: shared state encoding and line-level constants for the parity serial link
package par_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/par_tx_if.sv
// par_tx_if: request/data and serial-line bundle between a word source and par_tx
interface par_tx_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             out;
  logic             busy;
  logic             done;
  modport master (output start, data, input out, busy, done);
  modport slave  (input start, data, output out, busy, done);
endinterface

// File: rtl/par_tx_shift.sv
// par_tx_shift: load/shift register, bit counter and running parity for par_tx
module par_tx_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             bit_out,
  output logic             last,
  output logic             parity
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  always_ff @(posedge clk)
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sr     <= data_in;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      sr     <= sr >> 1;
      cnt    <= cnt + 1'b1;
      parity <= parity ^ sr[0];
    end
  assign bit_out = sr[0];
  assign last    = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/par_tx.sv
// par_tx: serial frame transmitter (start bit, LSB-first data, parity, stop bit)
module par_tx
  import par_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  par_tx_if.slave  bus
);
  state_t state;
  logic   accept, bit_out, last, parity;
  // STOP also accepts so back-to-back frames leave no idle gap
  assign accept = bus.start && (state == IDLE || state == STOP);
  par_tx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (state == DATA),
    .data_in (bus.data),
    .bit_out (bit_out),
    .last    (last),
    .parity  (parity)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else
      case (state)
        IDLE:    state <= accept ? START : IDLE;
        START:   state <= DATA;
        DATA:    state <= last ? PARITY : DATA;
        PARITY:  state <= STOP;
        STOP:    state <= accept ? START : IDLE;
        default: state <= IDLE;
      endcase
  assign bus.busy = state != IDLE;
  assign bus.done = state == STOP;
  assign bus.out  = state == START  ? START_BIT :
                    state == DATA   ? bit_out :
                    state == PARITY ? parity ^ ODD_PARITY :
                    state == STOP   ? STOP_BIT : LINE_IDLE;
endmodule

// File: tb/tb_par_tx.sv
// tb_par_tx: scoreboard bench for par_tx with an even-parity and an odd-parity instance
module tb_par_tx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  always #5 clk = ~clk;
  par_tx_if #(.WIDTH(W)) if_e ();
  par_tx_if #(.WIDTH(W)) if_o ();
  par_tx #(.WIDTH(W), .ODD_PARITY(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(if_e));
  par_tx #(.WIDTH(W), .ODD_PARITY(1'b1)) dut_o (.clk(clk), .rst(rst), .bus(if_o));

  function automatic void push_frame(logic [W-1:0] d, bit odd);
    exp_q.push_back(3'b010);
    for (int i = 0; i < W; i++) exp_q.push_back({d[i], 2'b10});
    exp_q.push_back({^d ^ odd, 2'b10});
    exp_q.push_back(3'b111);
  endfunction

  function automatic logic [2:0] obs(bit sel);
    return sel ? {if_o.out, if_o.busy, if_o.done} : {if_e.out, if_e.busy, if_e.done};
  endfunction

  task automatic set_in(bit sel, logic s, logic [W-1:0] d);
    if (sel) begin
      if_o.start = s;
      if_o.data  = d;
    end else begin
      if_e.start = s;
      if_e.data  = d;
    end
  endtask

  task automatic pulse(bit sel, logic [W-1:0] d);
    push_frame(d, sel);
    @(posedge clk);
    #1 set_in(sel, 1'b1, d);
    @(posedge clk);
    #1 set_in(sel, 1'b0, ~d);
  endtask

  task automatic check_frames(string name, bit sel, int n, int on, int off, logic [W-1:0] pd);
    logic [2:0] e, g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g = obs(sel);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s cyc%0d: scoreboard empty, got out/busy/done=%b", name, i, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s cyc%0d: out/busy/done got %b expected %b", name, i, g, e);
        end
      end
      if (i == on) set_in(sel, 1'b1, pd);
      if (i == off) set_in(sel, 1'b0, pd);
    end
  endtask

  task automatic check_idle(string name, bit sel, int n);
    logic [2:0] g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g = obs(sel);
      n_chk++;
      if (g !== 3'b100) begin
        n_fail++;
        $display("FAIL %s idle%0d: out/busy/done got %b expected 100", name, i, g);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset_even", 1'b0, 10);
    check_idle("reset_odd", 1'b1, 1);
  endtask

  task automatic test_frames();
    pulse(1'b0, 8'hA5);
    check_frames("even_a5", 1'b0, W + 3, -1, -1, '0);
    check_idle("even_a5", 1'b0, 1);
    pulse(1'b0, 8'h07);
    check_frames("even_07", 1'b0, W + 3, -1, -1, '0);
    check_idle("even_07", 1'b0, 1);
    pulse(1'b1, 8'hA5);
    check_frames("odd_a5", 1'b1, W + 3, -1, -1, '0);
    check_idle("odd_a5", 1'b1, 1);
    pulse(1'b1, 8'h00);
    check_frames("odd_00", 1'b1, W + 3, -1, -1, '0);
    check_idle("odd_00", 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] d;
      bit sel;
      d = W'($urandom);
      sel = k[0];
      pulse(sel, d);
      check_frames("random", sel, W + 3, -1, -1, '0);
      check_idle("random", sel, 1);
    end
  endtask

  task automatic test_back_to_back();
    push_frame(8'hFF, 1'b0);
    push_frame(8'h01, 1'b0);
    @(posedge clk);
    #1 set_in(1'b0, 1'b1, 8'hFF);
    @(posedge clk);
    #1 set_in(1'b0, 1'b1, 8'h01);
    check_frames("b2b", 1'b0, 2 * (W + 3), -1, 13, 8'h01);
    check_idle("b2b", 1'b0, 2);
  endtask

  task automatic test_start_while_busy();
    pulse(1'b0, 8'hC3);
    check_frames("busy_start", 1'b0, W + 3, 3, 4, 8'h0F);
    check_idle("busy_start", 1'b0, 3);
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] g;
    pulse(1'b0, 8'h3C);
    check_frames("rst_mid", 1'b0, W + 2, -1, -1, '0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    g = obs(1'b0);
    n_chk++;
    if (g !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_mid abort: out/busy/done got %b expected 100", g);
    end
    rst = 1'b0;
    pulse(1'b0, 8'h5A);
    check_frames("after_rst", 1'b0, W + 3, -1, -1, '0);
    check_idle("after_rst", 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
